pu_riscv_ram_queue_arbiter: RTL

- Shares one fall-through RAM queue between REQUESTERS write sources using round-robin arbitration.
- Drains the queue to a single valid/ready consumer.
- Sequences flush: stop writes, drain to empty, then pulse the queue's synchronous clear.
- Sits between the core's memory-request sources and the queue instance; the queue's ena_i is tied high by the integrator.

---
 rtl/pu_riscv_queue_arb_pkg.sv | 22 ++
 rtl/pu_riscv_rr_picker.sv | 38 +++
 rtl/pu_riscv_ram_queue_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pu_riscv_queue_arb_pkg.sv
// Shared types and helpers for the RAM queue arbiter.
//   arb_state_t  : arbiter FSM states (RUN, DRAIN, CLEAR)
//   ptr_width()  : width of a round-robin pointer over n requesters
//   DefRrPtrW    : pointer width for the default four requesters
package pu_riscv_queue_arb_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } arb_state_t;

    localparam int unsigned DefRequesters = 4;

    // Never returns zero, so a one-requester picker still has a legal pointer
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DefRrPtrW = ptr_width(DefRequesters);

endpackage

// File: rtl/pu_riscv_rr_picker.sv
// Combinational round-robin picker.
// It searches req_i from ptr_i upward and wraps from N-1 to 0.
// The first set bit wins.
//   req_i   : request vector
//   ptr_i   : search start position (must be < N)
//   gnt_o   : one-hot winner, zero when no request
//   idx_o   : index of the winner, zero when no request
//   valid_o : a winner exists
module pu_riscv_rr_picker
    import pu_riscv_queue_arb_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned PtrW = ptr_width(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [PtrW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [PtrW-1:0] idx_o,
    output logic            valid_o
);

    always_comb begin
        int unsigned k;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        k       = 0;
        for (int unsigned i = 0; i < N; i++) begin
            k = (int'(ptr_i) + i) % N;
            if (!valid_o && req_i[k]) begin
                valid_o  = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = PtrW'(k);
            end
        end
    end

endmodule

// File: rtl/pu_riscv_ram_queue_arbiter.sv
// Round-robin arbiter that shares one fall-through RAM queue between
// REQUESTERS write sources. It drains the queue to a single valid/ready consumer.
// A flush stops writes, waits for the queue to empty, then pulses the queue clear.
//   clk_i, rst_ni        : clock, synchronous active-low reset
//   flush_i              : level request to drain and clear the queue
//   req_i / req_d_i      : per-requester write request and data slices
//   gnt_o                : one-hot grant; data is written the same cycle
//   q_we_o / q_d_o       : queue write strobe and data
//   q_re_o / q_clr_o     : queue read strobe and synchronous clear
//   q_data_i / q_empty_i / q_full_i / q_almost_full_i : queue status and head data
//   valid_o / data_o / ready_i : consumer handshake
//   flush_done_o         : pulses in the cycle the clear is issued
//   busy_o               : a flush is in progress
module pu_riscv_ram_queue_arbiter
    import pu_riscv_queue_arb_pkg::*;
#(
    parameter int unsigned REQUESTERS     = 4,
    parameter int unsigned DBITS          = 64,
    parameter bit          STALL_ON_AFULL = 1'b0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic [REQUESTERS-1:0]       req_i,
    input  logic [REQUESTERS*DBITS-1:0] req_d_i,
    output logic [REQUESTERS-1:0]       gnt_o,
    output logic                        q_we_o,
    output logic [DBITS-1:0]            q_d_o,
    output logic                        q_re_o,
    output logic                        q_clr_o,
    input  logic [DBITS-1:0]            q_data_i,
    input  logic                        q_empty_i,
    input  logic                        q_full_i,
    input  logic                        q_almost_full_i,
    output logic                        valid_o,
    output logic [DBITS-1:0]            data_o,
    input  logic                        ready_i,
    output logic                        flush_done_o,
    output logic                        busy_o
);

    localparam int unsigned PtrW = ptr_width(REQUESTERS);

    arb_state_t      state_q, state_d;
    logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
    logic            q_clr_q, q_clr_d;
    logic            flush_done_q, flush_done_d;

    logic [REQUESTERS-1:0] pick_gnt;
    logic [PtrW-1:0]       pick_idx;
    logic                  pick_valid;
    logic                  wr_eligible;
    logic                  granted;
    logic                  rd_valid;
    logic                  rd_fire;

    pu_riscv_rr_picker #(
        .N    (REQUESTERS),
        .PtrW (PtrW)
    ) u_picker (
        .req_i   (req_i),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // Writes are blocked on full even if a read happens in the same cycle.
    // The full check then never depends on a same-cycle dequeue.
    always_comb begin
        wr_eligible = (state_q == RUN) && !q_full_i &&
                      (!STALL_ON_AFULL || !q_almost_full_i);
        granted     = wr_eligible && pick_valid;
        rd_valid    = !q_empty_i && (state_q != CLEAR);
        rd_fire     = rd_valid && ready_i;
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            RUN: begin
                if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (q_empty_i && !rd_fire) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (granted) begin
            rr_ptr_d = (pick_idx == PtrW'(REQUESTERS - 1)) ? '0 : pick_idx + PtrW'(1);
        end
        if (state_q == CLEAR) begin
            rr_ptr_d = '0;
        end

        // Registered strobes line up with the single CLEAR cycle
        q_clr_d      = (state_d == CLEAR);
        flush_done_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= RUN;
            rr_ptr_q     <= '0;
            q_clr_q      <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            q_clr_q      <= q_clr_d;
            flush_done_q <= flush_done_d;
        end
    end

    // Every output is held at zero while reset is asserted
    always_comb begin
        gnt_o        = '0;
        q_we_o       = 1'b0;
        q_d_o        = '0;
        q_re_o       = 1'b0;
        q_clr_o      = 1'b0;
        valid_o      = 1'b0;
        data_o       = '0;
        flush_done_o = 1'b0;
        busy_o       = 1'b0;
        if (rst_ni) begin
            if (granted) begin
                gnt_o  = pick_gnt;
                q_we_o = 1'b1;
                q_d_o  = req_d_i[int'(pick_idx)*DBITS +: DBITS];
            end
            valid_o      = rd_valid;
            data_o       = q_data_i;
            q_re_o       = rd_fire;
            q_clr_o      = q_clr_q;
            flush_done_o = flush_done_q;
            busy_o       = (state_q != RUN);
        end
    end

endmodule
